// File: rtl/ising_config.sv
// Shared definitions for the scaler pivot loader: gpio word layout, tree
// geometry, loader state encoding and the heap-order pivot position helper.
package ising_config;

    localparam int unsigned GPIO_W     = 32;
    localparam int unsigned DATA_LSB   = 0;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ADDR_LSB   = 16;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned STROBE_BIT = 24;

    localparam int unsigned TREE_NODES = 255;
    localparam int unsigned TREE_DEPTH = 8;
    localparam int unsigned NODE_W     = TREE_DEPTH;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_WRITE = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Word driven into the scaler tree's gpio_in.
    typedef struct packed {
        logic [6:0]        zero;
        logic              strobe;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } gpio_word_t;

    // Bin index of heap node n: depth d = msb(n+1), position j = n+1-2^d,
    // k = (2j+1) * 2^(7-d). Clearing bit d of n+1 yields j directly.
    function automatic logic [NODE_W-1:0] node_k(input logic [NODE_W-1:0] n);
        logic [NODE_W-1:0] m;
        logic [NODE_W-1:0] j;
        logic [2:0]        d;
        m = n + NODE_W'(1);
        d = 3'd0;
        for (int i = 0; i < int'(NODE_W); i++) begin
            if (m[i]) d = 3'(i);
        end
        j    = m;
        j[d] = 1'b0;
        return NODE_W'({j[NODE_W-2:0], 1'b1} << (3'd7 - d));
    endfunction

endpackage

// File: rtl/scaler_pivot_loader_if.sv
// Host/tree-side bundle of the pivot loader.
//   gpio_in   : host configuration word (passed through when idle)
//   start     : one-cycle pulse, begins a pivot load
//   abort     : one-cycle pulse, cancels a load in progress
//   base/step : signed lower edge / unsigned bin width of the input range
//   gpio_out  : registered word to the scaler tree
//   busy/done/collision : load status
interface scaler_pivot_loader_if;

    logic [31:0]        gpio_in;
    logic               start;
    logic               abort;
    logic signed [15:0] base;
    logic [15:0]        step;
    logic [31:0]        gpio_out;
    logic               busy;
    logic               done;
    logic               collision;

    modport master (
        output gpio_in, start, abort, base, step,
        input  gpio_out, busy, done, collision
    );

    modport slave (
        input  gpio_in, start, abort, base, step,
        output gpio_out, busy, done, collision
    );

endinterface

// File: rtl/pivot_calc.sv
// Combinational pivot generator for one tree node.
//   n_i     : node index in heap order (0..254)
//   base_i  : signed lower edge
//   step_i  : unsigned bin width
//   pivot_o : base + k*step saturated to 16-bit signed
//   addr_o  : START_ADDR + n modulo 256
module pivot_calc
    import ising_config::*;
#(
    parameter int unsigned START_ADDR = 0
) (
    input  logic [NODE_W-1:0]        n_i,
    input  logic signed [DATA_W-1:0] base_i,
    input  logic [DATA_W-1:0]        step_i,
    output logic [DATA_W-1:0]        pivot_o,
    output logic [ADDR_W-1:0]        addr_o
);

    localparam int unsigned PROD_W = NODE_W + DATA_W;
    localparam int unsigned SUM_W  = PROD_W + 2;
    localparam logic signed [SUM_W-1:0] PIV_MAX = SUM_W'(32767);
    localparam logic signed [SUM_W-1:0] PIV_MIN = -SUM_W'(32768);

    logic [NODE_W-1:0]       k;
    logic [PROD_W-1:0]       prod;
    logic signed [SUM_W-1:0] sum;

    // Wide signed sum so the saturation compare sees the true value.
    always_comb begin
        k    = node_k(n_i);
        prod = PROD_W'(k) * PROD_W'(step_i);
        sum  = SUM_W'(base_i) + $signed(SUM_W'(prod));
        if (sum > PIV_MAX) begin
            pivot_o = 16'h7FFF;
        end else if (sum < PIV_MIN) begin
            pivot_o = 16'h8000;
        end else begin
            pivot_o = sum[DATA_W-1:0];
        end
        addr_o = ADDR_W'(START_ADDR) + n_i;
    end

endmodule

// File: rtl/scaler_pivot_loader.sv
// Loads the 255 pivots of a binary scaler tree over the gpio word bus,
// one node every three cycles (CALC, WRITE strobe, GAP), and passes the
// host word through while idle.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : scaler_pivot_loader_if.slave (gpio_in/start/abort/base/step in,
//         gpio_out/busy/done/collision out, all outputs registered)
module scaler_pivot_loader
    import ising_config::*;
#(
    parameter int unsigned START_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    scaler_pivot_loader_if.slave  bus
);

    if (START_ADDR > 1) begin : g_bad_start_addr
        $error("scaler_pivot_loader: START_ADDR must be 0 or 1");
    end

    state_e                   state_q, state_d;
    logic [NODE_W-1:0]        n_q, n_d;
    logic signed [DATA_W-1:0] base_q, base_d;
    logic [DATA_W-1:0]        step_q, step_d;
    logic [GPIO_W-1:0]        gpio_out_q, gpio_out_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     collision_q, collision_d;

    logic [DATA_W-1:0]        pivot_c;
    logic [ADDR_W-1:0]        addr_c;
    gpio_word_t               wr_word_c;

    pivot_calc #(
        .START_ADDR (START_ADDR)
    ) u_pivot_calc (
        .n_i     (n_q),
        .base_i  (base_q),
        .step_i  (step_q),
        .pivot_o (pivot_c),
        .addr_o  (addr_c)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            base_q      <= '0;
            step_q      <= '0;
            gpio_out_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            base_q      <= base_d;
            step_q      <= step_d;
            gpio_out_q  <= gpio_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            collision_q <= collision_d;
        end
    end

    // Next state; outputs are computed for the cycle being entered.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        base_d      = base_q;
        step_d      = step_q;
        gpio_out_d  = gpio_out_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        collision_d = collision_q;

        wr_word_c        = '0;
        wr_word_c.strobe = 1'b1;
        wr_word_c.addr   = addr_c;
        wr_word_c.data   = pivot_c;

        unique case (state_q)
            ST_IDLE: begin
                gpio_out_d = bus.gpio_in;
                if (bus.start) begin
                    state_d     = ST_CALC;
                    n_d         = '0;
                    base_d      = bus.base;
                    step_d      = bus.step;
                    collision_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            ST_CALC: begin
                if (bus.abort) begin
                    state_d    = ST_IDLE;
                    gpio_out_d = '0;
                end else begin
                    state_d    = ST_WRITE;
                    gpio_out_d = wr_word_c;
                    busy_d     = 1'b1;
                end
            end
            ST_WRITE: begin
                if (bus.abort) begin
                    state_d    = ST_IDLE;
                    gpio_out_d = '0;
                end else begin
                    state_d                = ST_GAP;
                    gpio_out_d[STROBE_BIT] = 1'b0;
                    busy_d                 = 1'b1;
                end
            end
            ST_GAP: begin
                gpio_out_d = '0;
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (n_q == NODE_W'(TREE_NODES - 1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_CALC;
                    n_d     = n_q + NODE_W'(1);
                    busy_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                gpio_out_d = '0;
            end
            default: begin
                state_d    = ST_IDLE;
                gpio_out_d = '0;
            end
        endcase

        // Host writes are dropped while loading; remember that one was lost.
        if ((state_q == ST_CALC || state_q == ST_WRITE || state_q == ST_GAP)
            && bus.gpio_in[STROBE_BIT]) begin
            collision_d = 1'b1;
        end
    end

    assign bus.gpio_out  = gpio_out_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.collision = collision_q;

endmodule

// File: tb/tb_scaler_pivot_loader.sv
module tb_scaler_pivot_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scaler_pivot_loader_if bus();

    scaler_pivot_loader #(.START_ADDR(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference: bin index of each heap node by splitting [0,256) breadth-first.
    int exp_k[255];

    int s_addr[$];
    int s_data[$];
    int s_cyc[$];
    int done_cyc;
    int done_cnt;
    int busy_cnt;
    logic [31:0] done_gpio;

    function automatic void build_model();
        int lo_q[$];
        int hi_q[$];
        int lo;
        int hi;
        lo_q.push_back(0);
        hi_q.push_back(256);
        for (int n = 0; n < 255; n++) begin
            lo = lo_q.pop_front();
            hi = hi_q.pop_front();
            exp_k[n] = (lo + hi) / 2;
            lo_q.push_back(lo);
            hi_q.push_back(exp_k[n]);
            lo_q.push_back(exp_k[n]);
            hi_q.push_back(hi);
        end
    endfunction

    function automatic int exp_pivot(input int b, input int s, input int n);
        int v;
        v = b + exp_k[n] * s;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    // Runs one load from a start pulse and records strobes (cycle = negedges after start).
    task automatic do_load(input int b, input int s, input bit inject, input bit wiggle, input bit with_abort);
        logic signed [15:0] d16;
        s_addr.delete(); s_data.delete(); s_cyc.delete();
        done_cyc = -1; done_cnt = 0; busy_cnt = 0; done_gpio = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.abort = with_abort;
        bus.base = 16'(b); bus.step = 16'(s); bus.gpio_in = '0;
        for (int k = 1; k <= 900; k++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.gpio_out[24]) begin
                d16 = bus.gpio_out[15:0];
                s_addr.push_back(int'(bus.gpio_out[23:16]));
                s_data.push_back(int'(d16));
                s_cyc.push_back(k);
            end
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = k; done_gpio = bus.gpio_out; end
            end
            bus.abort = 1'b0;
            bus.start = wiggle && k < 700 && ($urandom_range(0, 15) == 0);
            if (wiggle) begin bus.base = 16'($urandom); bus.step = 16'($urandom); end
            bus.gpio_in = (inject && k < 760) ? ($urandom | 32'h0100_0000) : 32'h0;
            if (done_cyc >= 0 && k >= done_cyc + 2) break;
        end
        bus.start = 1'b0; bus.gpio_in = '0;
        if (done_cyc < 0) begin
            tests++; fails++;
            $display("FAIL load_timeout: no done within 900 cycles (base %0d step %0d)", b, s);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.gpio_in = 32'hDEAD_BEEF; bus.start = 1'b0; bus.abort = 1'b0;
        bus.base = '0; bus.step = '0;
        repeat (3) @(negedge clk);
        tests++; if (bus.gpio_out !== 32'h0) begin fails++; $display("FAIL reset_gpio_out: got %h expected 0", bus.gpio_out); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        tests++; if (bus.collision !== 1'b0) begin fails++; $display("FAIL reset_collision: got %b expected 0", bus.collision); end
        rst = 1'b1;
        bus.gpio_in = '0;
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        logic [31:0] w;
        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            bus.gpio_in = w;
            bus.abort = $urandom_range(0, 1);
            @(negedge clk);
            tests++;
            if (bus.gpio_out !== w || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                fails++;
                $display("FAIL passthrough_%0d: got %h busy %b done %b expected %h busy 0 done 0", i, bus.gpio_out, bus.busy, bus.done, w);
            end
        end
        bus.abort = 1'b0; bus.gpio_in = '0;
        tests++; if (bus.collision !== 1'b0) begin fails++; $display("FAIL passthrough_collision: got %b expected 0", bus.collision); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        int exp_a[4] = '{0, 1, 2, 254};
        int exp_d[4] = '{128, 64, 192, 255};
        do_load(0, 1, 1'b0, 1'b0, 1'b0);
        tests++; if (s_addr.size() !== 255) begin fails++; $display("FAIL basic_count: got %0d expected 255", s_addr.size()); end
        for (int i = 0; i < s_addr.size() && i < 255; i++) begin
            tests++;
            if (s_addr[i] !== i || s_data[i] !== exp_pivot(0, 1, i) || s_cyc[i] !== 2 + 3 * i) begin
                fails++;
                $display("FAIL basic_node%0d: got addr %0d data %0d cyc %0d expected addr %0d data %0d cyc %0d",
                         i, s_addr[i], s_data[i], s_cyc[i], i, exp_pivot(0, 1, i), 2 + 3 * i);
            end
        end
        if (s_addr.size() == 255) begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (s_addr[exp_a[i]] !== exp_a[i] || s_data[exp_a[i]] !== exp_d[i]) begin
                    fails++;
                    $display("FAIL basic_point%0d: got (%0d,%0d) expected (%0d,%0d)", i, s_addr[exp_a[i]], s_data[exp_a[i]], exp_a[i], exp_d[i]);
                end
            end
        end
        tests++; if (done_cyc !== 766) begin fails++; $display("FAIL basic_done_cycle: got %0d expected 766", done_cyc); end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
        tests++; if (busy_cnt !== 765) begin fails++; $display("FAIL basic_busy_cycles: got %0d expected 765", busy_cnt); end
        tests++; if (done_gpio !== 32'h0) begin fails++; $display("FAIL basic_done_gpio: got %h expected 0", done_gpio); end
    endtask

    task automatic test_saturate();
        do_load(32000, 100, 1'b0, 1'b0, 1'b0);
        tests++;
        if (s_data.size() != 255 || s_data[0] !== 32767) begin
            fails++; $display("FAIL sat_root: got %0d strobes, root %0d expected 255 strobes, root 32767",
                              s_data.size(), (s_data.size() > 0) ? s_data[0] : 0);
        end
        for (int i = 0; i < s_data.size() && i < 255; i++) begin
            tests++;
            if (s_data[i] !== exp_pivot(32000, 100, i)) begin
                fails++; $display("FAIL sat_node%0d: got %0d expected %0d", i, s_data[i], exp_pivot(32000, 100, i));
            end
        end
    endtask

    task automatic test_negative();
        do_load(-32768, 256, 1'b0, 1'b0, 1'b0);
        tests++;
        if (s_data.size() != 255 || s_data[0] !== 0 || s_data[254] !== 32512) begin
            fails++; $display("FAIL neg_points: got %0d strobes, root %0d, last %0d expected 255, 0, 32512",
                              s_data.size(), (s_data.size() > 0) ? s_data[0] : 0,
                              (s_data.size() > 254) ? s_data[254] : 0);
        end
    endtask

    task automatic test_random_loads();
        int b;
        int s;
        for (int r = 0; r < 4; r++) begin
            b = int'($signed(16'($urandom)));
            s = int'($urandom_range(0, 65535));
            do_load(b, s, 1'b0, 1'b1, r[0]);
            tests++; if (s_addr.size() !== 255) begin fails++; $display("FAIL rand%0d_count: got %0d expected 255", r, s_addr.size()); end
            tests++; if (done_cyc !== 766 || done_cnt !== 1) begin fails++; $display("FAIL rand%0d_done: got cycle %0d count %0d expected 766 1", r, done_cyc, done_cnt); end
            for (int i = 0; i < s_addr.size() && i < 255; i++) begin
                tests++;
                if (s_addr[i] !== i || s_data[i] !== exp_pivot(b, s, i)) begin
                    fails++;
                    $display("FAIL rand%0d_node%0d: got (%0d,%0d) expected (%0d,%0d) base %0d step %0d",
                             r, i, s_addr[i], s_data[i], i, exp_pivot(b, s, i), b, s);
                end
            end
        end
    endtask

    task automatic test_abort();
        int strobes = 0;
        int late = 0;
        int dones = 0;
        logic [31:0] w;
        bit hit = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.base = 16'sd0; bus.step = 16'd1; bus.gpio_in = '0;
        for (int k = 1; k <= 100 && !hit; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.gpio_out[24]) strobes++;
            if (strobes == 10) hit = 1'b1;
        end
        tests++; if (!hit) begin fails++; $display("FAIL abort_reach: got %0d strobes expected 10", strobes); end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.gpio_out !== 32'h0) begin fails++; $display("FAIL abort_gpio: got %h expected 0", bus.gpio_out); end
        w = $urandom & 32'hFEFF_FFFF;
        bus.gpio_in = w;
        @(negedge clk);
        tests++; if (bus.gpio_out !== w) begin fails++; $display("FAIL abort_passthrough: got %h expected %h", bus.gpio_out, w); end
        bus.gpio_in = '0;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if (bus.gpio_out[24]) late++;
            if (bus.done) dones++;
        end
        tests++; if (late !== 0 || dones !== 0) begin fails++; $display("FAIL abort_quiet: got %0d strobes %0d dones expected 0 0", late, dones); end
    endtask

    task automatic test_collision();
        do_load(0, 1, 1'b1, 1'b0, 1'b0);
        tests++; if (bus.collision !== 1'b1) begin fails++; $display("FAIL coll_set: got %b expected 1", bus.collision); end
        tests++; if (s_addr.size() !== 255) begin fails++; $display("FAIL coll_count: got %0d expected 255", s_addr.size()); end
        for (int i = 0; i < s_addr.size() && i < 255; i++) begin
            tests++;
            if (s_addr[i] !== i || s_data[i] !== exp_pivot(0, 1, i)) begin
                fails++; $display("FAIL coll_node%0d: got (%0d,%0d) expected (%0d,%0d)", i, s_addr[i], s_data[i], i, exp_pivot(0, 1, i));
            end
        end
        repeat (3) @(negedge clk);
        tests++; if (bus.collision !== 1'b1) begin fails++; $display("FAIL coll_sticky: got %b expected 1", bus.collision); end
        do_load(100, 3, 1'b0, 1'b0, 1'b0);
        tests++; if (bus.collision !== 1'b0) begin fails++; $display("FAIL coll_clear: got %b expected 0", bus.collision); end
    endtask

    task automatic test_reset_midload();
        logic coll_before = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.base = 16'sd5; bus.step = 16'd7; bus.gpio_in = '0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == 299) coll_before = bus.collision;
            bus.gpio_in = (k < 299) ? ($urandom | 32'h0100_0000) : 32'h0;
        end
        tests++; if (coll_before !== 1'b1) begin fails++; $display("FAIL midrst_coll_before: got %b expected 1", coll_before); end
        rst = 1'b0;
        #1;
        tests++;
        if (bus.gpio_out !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.collision !== 1'b0) begin
            fails++;
            $display("FAIL midrst_outputs: got gpio %h busy %b done %b coll %b expected all 0", bus.gpio_out, bus.busy, bus.done, bus.collision);
        end
        @(negedge clk);
        rst = 1'b1;
        do_load(5, 7, 1'b0, 1'b0, 1'b0);
        tests++; if (s_addr.size() !== 255) begin fails++; $display("FAIL midrst_count: got %0d expected 255", s_addr.size()); end
        for (int i = 0; i < s_addr.size() && i < 255; i++) begin
            tests++;
            if (s_addr[i] !== i || s_data[i] !== exp_pivot(5, 7, i) || s_cyc[i] !== 2 + 3 * i) begin
                fails++; $display("FAIL midrst_node%0d: got (%0d,%0d) cyc %0d expected (%0d,%0d) cyc %0d",
                                  i, s_addr[i], s_data[i], s_cyc[i], i, exp_pivot(5, 7, i), 2 + 3 * i);
            end
        end
    endtask

    initial begin
        build_model();
        test_reset();
        test_passthrough();
        test_basic();
        test_saturate();
        test_negative();
        test_random_loads();
        test_abort();
        test_collision();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scaler_pivot_loader.md
SCALER_PIVOT_LOADER -- requirements
Module: scaler_pivot_loader

Interface
REQ-001 Parameter START_ADDR, default 0: bus address of the root tree node; legal values are 0 and 1, and any other value SHALL fail elaboration.
REQ-002 clk  input  1  single system clock; all logic is on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 gpio_in  input  32  host configuration word, passed through when idle.
REQ-005 start  input  1  one-cycle pulse; begins a pivot load.
REQ-006 abort  input  1  one-cycle pulse; cancels a load in progress.
REQ-007 base  input  16  signed lower edge of the input range.
REQ-008 step  input  16  unsigned bin width.
REQ-009 gpio_out  output  32  registered word driven to the scaler tree's gpio_in.
REQ-010 busy  output  1  high while a load is in progress.
REQ-011 done  output  1  one-cycle pulse when all 255 pivots have been written.
REQ-012 collision  output  1  sticky flag: a host write arrived while busy.

Function
REQ-013 gpio word format: [15:0] data, [23:16] address, [24] write strobe, [31:25] zero.
REQ-014 State machine: IDLE, CALC, WRITE, GAP, DONE.
REQ-015 IDLE: gpio_out <= gpio_in every cycle (one-cycle registered pass-through).
REQ-016 IDLE: start=1 -> capture base and step, node index n=0, clear collision, go to CALC.
REQ-017 CALC (1 cycle):
- depth d = floor(log2(n+1)), position j = n+1-2^d
- k = (2j+1)*2^(7-d), range 1..255
- pivot = base + k*step, computed at least 25 bits signed, saturated to [-32768, 32767]
- address = START_ADDR + n, taken modulo 256
REQ-018 WRITE (1 cycle): gpio_out = {7'b0, 1, address, pivot}.
REQ-019 GAP (1 cycle): gpio_out = {7'b0, 0, address, pivot}.
REQ-020 After GAP: n<254 -> n+1, go to CALC; n=254 -> go to DONE.
REQ-021 Per-node cost is 3 cycles; start sampled at cycle 0 gives the first strobe at cycle 2 and the last strobe at cycle 764.
REQ-022 DONE (1 cycle): done=1, gpio_out=0, then go to IDLE.
REQ-023 busy=1 in CALC, WRITE and GAP; 0 in IDLE and DONE.
REQ-024 start is ignored when not in IDLE.
REQ-025 abort in CALC, WRITE or GAP -> next cycle IDLE, gpio_out=0 that cycle, no done pulse.
REQ-026 abort in IDLE is ignored; abort together with start in IDLE -> start wins.
REQ-027 While busy, gpio_in is dropped; gpio_in[24]=1 sets collision.
REQ-028 collision holds until the next accepted start or reset.
REQ-029 base and step changes after capture SHALL NOT affect a load in progress.

Reset
REQ-030 rst low -> immediately IDLE, n=0, gpio_out=0, busy=0, done=0, collision=0.
REQ-031 Reset mid-load abandons the load; no partial-state recovery is required.

Structure
REQ-032 Shared package ising_config holds:
- gpio field positions: data LSB/width, address LSB/width, strobe bit
- TREE_NODES=255 and TREE_DEPTH=8
- the state enum typedef
REQ-033 Optional sub-module pivot_calc: combinational n, base, step -> pivot, address.

Verification
REQ-034 base=0, step=1, START_ADDR=0 -> strobed writes (addr, data):
- node 0: (0, 128); node 1: (1, 64); node 2: (2, 192); node 254: (254, 255)
- done at cycle 766; exactly 255 strobes in total.
REQ-035 base=32000, step=100 -> root pivot saturates to 32767.
REQ-036 base=-32768, step=256 -> root pivot 0, node 254 pivot 32512.
REQ-037 Abort after 10 strobes -> no further strobes, busy=0 next cycle, no done; gpio_in passes through 2 cycles after abort.
REQ-038 Host word with bit24=1 during a load -> not forwarded, collision=1; next start clears collision.
REQ-039 rst low at cycle 300 of a load -> all outputs 0 immediately; a fresh start afterwards completes 255 writes from node 0.
